// File: rtl/slug_exec_units.sv
// -----------------------------------------------------------------------------
// slug_exec_units
// The three non-storage functional units of the 4-bit slug CPU:
//   - 16-bit program counter with load and increment (the only clocked state)
//   - 74181-style 4-bit ALU (combinational)
//   - 3-to-8 one-hot select decoder (combinational)
//
// Ports:
//   clk       system clock, program counter updates on rising edge
//   rst       synchronous active-low reset
//   pc_ld     load program counter from pc_d (wins over pc_inc)
//   pc_inc    increment program counter (wraps modulo 2^PC_WIDTH)
//   pc_d      load value from the address bus
//   pc_q      registered program counter (program ROM address)
//   alu_s     ALU function select S3..S0
//   alu_m     ALU mode: 1 = logic, 0 = arithmetic
//   alu_cn    ALU carry-in, active-low
//   alu_a     operand A (accumulator)
//   alu_b     operand B
//   alu_f     ALU result
//   alu_cn4   ALU carry-out, active-low (forced high in logic mode)
//   alu_zero  high when alu_f is zero
//   sel       decoder select
//   dsel      one-hot active-high decode of sel
// -----------------------------------------------------------------------------
module slug_exec_units #(
  parameter int                    PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   PC_RESET = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_ld,
  input  logic                pc_inc,
  input  logic [PC_WIDTH-1:0] pc_d,
  output logic [PC_WIDTH-1:0] pc_q,
  input  logic [3:0]          alu_s,
  input  logic                alu_m,
  input  logic                alu_cn,
  input  logic [3:0]          alu_a,
  input  logic [3:0]          alu_b,
  output logic [3:0]          alu_f,
  output logic                alu_cn4,
  output logic                alu_zero,
  input  logic [2:0]          sel,
  output logic [7:0]          dsel
);

  logic [PC_WIDTH-1:0] pc_r;
  logic [3:0]          alu_logic_s;
  logic [3:0]          alu_x_s;
  logic [3:0]          alu_y_s;
  logic [4:0]          alu_sum_s;
  logic [3:0]          alu_f_s;
  logic                alu_cn4_s;
  logic [7:0]          dsel_s;

  // Program counter: reset > load > increment > hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r <= PC_RESET;
    end else if (pc_ld) begin
      pc_r <= pc_d;
    end else if (pc_inc) begin
      pc_r <= pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc_q = pc_r;

  // Logic-mode function table.
  always_comb begin
    alu_logic_s = 4'h0;
    case (alu_s)
      4'h0:    alu_logic_s = ~alu_a;
      4'h1:    alu_logic_s = ~(alu_a | alu_b);
      4'h2:    alu_logic_s = ~alu_a & alu_b;
      4'h3:    alu_logic_s = 4'h0;
      4'h4:    alu_logic_s = ~(alu_a & alu_b);
      4'h5:    alu_logic_s = ~alu_b;
      4'h6:    alu_logic_s = alu_a ^ alu_b;
      4'h7:    alu_logic_s = alu_a & ~alu_b;
      4'h8:    alu_logic_s = ~alu_a | alu_b;
      4'h9:    alu_logic_s = ~(alu_a ^ alu_b);
      4'hA:    alu_logic_s = alu_b;
      4'hB:    alu_logic_s = alu_a & alu_b;
      4'hC:    alu_logic_s = 4'hF;
      4'hD:    alu_logic_s = alu_a | ~alu_b;
      4'hE:    alu_logic_s = alu_a | alu_b;
      4'hF:    alu_logic_s = alu_a;
      default: alu_logic_s = 4'h0;
    endcase
  end

  // Arithmetic mode is X + Y + carry; every 74181 arithmetic function is
  // expressed as a pair of addends so one 5-bit adder yields both result and
  // carry. "Minus one" terms are an addend of 4'hF.
  always_comb begin
    alu_x_s = 4'h0;
    alu_y_s = 4'h0;
    case (alu_s)
      4'h0:    begin alu_x_s = alu_a;             alu_y_s = 4'h0;             end
      4'h1:    begin alu_x_s = alu_a | alu_b;     alu_y_s = 4'h0;             end
      4'h2:    begin alu_x_s = alu_a | ~alu_b;    alu_y_s = 4'h0;             end
      4'h3:    begin alu_x_s = 4'h0;              alu_y_s = 4'hF;             end
      4'h4:    begin alu_x_s = alu_a;             alu_y_s = alu_a & ~alu_b;   end
      4'h5:    begin alu_x_s = alu_a | alu_b;     alu_y_s = alu_a & ~alu_b;   end
      4'h6:    begin alu_x_s = alu_a;             alu_y_s = ~alu_b;           end
      4'h7:    begin alu_x_s = alu_a & ~alu_b;    alu_y_s = 4'hF;             end
      4'h8:    begin alu_x_s = alu_a;             alu_y_s = alu_a & alu_b;    end
      4'h9:    begin alu_x_s = alu_a;             alu_y_s = alu_b;            end
      4'hA:    begin alu_x_s = alu_a | ~alu_b;    alu_y_s = alu_a & alu_b;    end
      4'hB:    begin alu_x_s = alu_a & alu_b;     alu_y_s = 4'hF;             end
      4'hC:    begin alu_x_s = alu_a;             alu_y_s = alu_a;            end
      4'hD:    begin alu_x_s = alu_a | alu_b;     alu_y_s = alu_a;            end
      4'hE:    begin alu_x_s = alu_a | ~alu_b;    alu_y_s = alu_a;            end
      4'hF:    begin alu_x_s = alu_a;             alu_y_s = 4'hF;             end
      default: begin alu_x_s = 4'h0;              alu_y_s = 4'h0;             end
    endcase
  end

  // Carry-in is active-low, so the adder adds its complement.
  assign alu_sum_s = {1'b0, alu_x_s} + {1'b0, alu_y_s} + {4'h0, ~alu_cn};

  // Mode select; logic mode ignores carry-in and drives carry-out inactive.
  always_comb begin
    alu_f_s   = 4'h0;
    alu_cn4_s = 1'b1;
    if (alu_m) begin
      alu_f_s   = alu_logic_s;
      alu_cn4_s = 1'b1;
    end else begin
      alu_f_s   = alu_sum_s[3:0];
      alu_cn4_s = ~alu_sum_s[4];
    end
  end

  assign alu_f    = alu_f_s;
  assign alu_cn4  = alu_cn4_s;
  assign alu_zero = (alu_f_s == 4'h0);

  // One-hot select decode; always exactly one bit set.
  always_comb begin
    dsel_s = 8'h00;
    dsel_s = 8'h01 << sel;
  end

  assign dsel = dsel_s;

endmodule

// File: tb/tb_slug_exec_units.sv
// -----------------------------------------------------------------------------
// tb_slug_exec_units
// Directed self-checking bench for slug_exec_units: program counter sequencing
// (reset, increment, load, wrap, hold, synchronous reset), ALU arithmetic and
// logic vectors, and the full decoder sweep.
// -----------------------------------------------------------------------------
module tb_slug_exec_units;

  logic        clk;
  logic        rst;
  logic        pc_ld;
  logic        pc_inc;
  logic [15:0] pc_d;
  logic [15:0] pc_q;
  logic [3:0]  alu_s;
  logic        alu_m;
  logic        alu_cn;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_f;
  logic        alu_cn4;
  logic        alu_zero;
  logic [2:0]  sel;
  logic [7:0]  dsel;

  int checks_cnt;
  int errors_cnt;

  slug_exec_units #(
    .PC_WIDTH (16),
    .PC_RESET (16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .pc_d     (pc_d),
    .pc_q     (pc_q),
    .alu_s    (alu_s),
    .alu_m    (alu_m),
    .alu_cn   (alu_cn),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_f    (alu_f),
    .alu_cn4  (alu_cn4),
    .alu_zero (alu_zero),
    .sel      (sel),
    .dsel     (dsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one ALU vector and check result, carry-out and zero flag.
  task automatic alu_vec(input string tag, input logic m, input logic [3:0] s,
                         input logic cn, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_f, input logic exp_cn4,
                         input logic exp_zero);
    alu_m  = m;
    alu_s  = s;
    alu_cn = cn;
    alu_a  = a;
    alu_b  = b;
    #1;
    chk({tag, "_f"},    16'(alu_f),    16'(exp_f));
    chk({tag, "_cn4"},  16'(alu_cn4),  16'(exp_cn4));
    chk({tag, "_zero"}, 16'(alu_zero), 16'(exp_zero));
  endtask

  logic [7:0] dsel_exp [8];

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst    = 1'b0;
    pc_ld  = 1'b0;
    pc_inc = 1'b0;
    pc_d   = 16'h0000;
    alu_s  = 4'h0;
    alu_m  = 1'b0;
    alu_cn = 1'b1;
    alu_a  = 4'h0;
    alu_b  = 4'h0;
    sel    = 3'd0;
    dsel_exp[0] = 8'h01; dsel_exp[1] = 8'h02; dsel_exp[2] = 8'h04; dsel_exp[3] = 8'h08;
    dsel_exp[4] = 8'h10; dsel_exp[5] = 8'h20; dsel_exp[6] = 8'h40; dsel_exp[7] = 8'h80;

    // Program counter: reset, then count.
    tick();
    chk("pc_reset", pc_q, 16'h0000);
    rst    = 1'b1;
    pc_inc = 1'b1;
    tick(); chk("pc_inc1", pc_q, 16'h0001);
    tick(); chk("pc_inc2", pc_q, 16'h0002);
    tick(); chk("pc_inc3", pc_q, 16'h0003);

    // Load top of range, then wrap.
    pc_ld = 1'b1;
    pc_d  = 16'hFFFF;
    tick(); chk("pc_ld_ffff", pc_q, 16'hFFFF);
    pc_ld = 1'b0;
    tick(); chk("pc_wrap", pc_q, 16'h0000);

    // Load beats increment; then hold.
    pc_ld  = 1'b1;
    pc_inc = 1'b1;
    pc_d   = 16'h1234;
    tick(); chk("pc_ld_prio", pc_q, 16'h1234);
    pc_ld  = 1'b0;
    pc_inc = 1'b0;
    pc_d   = 16'hABCD;
    tick(); chk("pc_hold1", pc_q, 16'h1234);
    tick(); chk("pc_hold2", pc_q, 16'h1234);

    // Synchronous reset only lands on the next edge.
    pc_inc = 1'b1;
    rst    = 1'b0;
    #1;
    chk("pc_rst_not_yet", pc_q, 16'h1234);
    tick(); chk("pc_rst_sync", pc_q, 16'h0000);
    tick(); chk("pc_rst_held", pc_q, 16'h0000);
    rst = 1'b1;
    tick(); chk("pc_after_rst", pc_q, 16'h0001);
    pc_inc = 1'b0;

    // ALU addition, S=9, no carry-in.
    alu_vec("add_5_3", 1'b0, 4'h9, 1'b1, 4'h5, 4'h3, 4'h8, 1'b1, 1'b0);
    alu_vec("add_9_9", 1'b0, 4'h9, 1'b1, 4'h9, 4'h9, 4'h2, 1'b0, 1'b0);
    alu_vec("add_8_8", 1'b0, 4'h9, 1'b1, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1);

    // ALU subtraction, S=6.
    alu_vec("sub_5_3",    1'b0, 4'h6, 1'b0, 4'h5, 4'h3, 4'h2, 1'b0, 1'b0);
    alu_vec("sub_3_5",    1'b0, 4'h6, 1'b0, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0);
    alu_vec("sub_5_3_m1", 1'b0, 4'h6, 1'b1, 4'h5, 4'h3, 4'h1, 1'b0, 1'b0);

    // Arithmetic boundaries: minus one with and without carry, A-1 at zero.
    alu_vec("m1_nc",  1'b0, 4'h3, 1'b1, 4'h7, 4'h2, 4'hF, 1'b1, 1'b0);
    alu_vec("m1_c",   1'b0, 4'h3, 1'b0, 4'h7, 4'h2, 4'h0, 1'b0, 1'b1);
    alu_vec("dec_0",  1'b0, 4'hF, 1'b1, 4'h0, 4'h5, 4'hF, 1'b1, 1'b0);
    alu_vec("dbl_9",  1'b0, 4'hC, 1'b1, 4'h9, 4'h0, 4'h2, 1'b0, 1'b0);

    // ALU logic mode, A=A B=6, both carry-in levels.
    for (int c = 0; c < 2; c++) begin
      alu_vec("lg_xor", 1'b1, 4'h6, c[0], 4'hA, 4'h6, 4'hC, 1'b1, 1'b0);
      alu_vec("lg_and", 1'b1, 4'hB, c[0], 4'hA, 4'h6, 4'h2, 1'b1, 1'b0);
      alu_vec("lg_or",  1'b1, 4'hE, c[0], 4'hA, 4'h6, 4'hE, 1'b1, 1'b0);
      alu_vec("lg_nota",1'b1, 4'h0, c[0], 4'hA, 4'h6, 4'h5, 1'b1, 1'b0);
      alu_vec("lg_zero",1'b1, 4'h3, c[0], 4'hA, 4'h6, 4'h0, 1'b1, 1'b1);
      alu_vec("lg_ones",1'b1, 4'hC, c[0], 4'hA, 4'h6, 4'hF, 1'b1, 1'b0);
    end

    // Decoder sweep.
    for (int i = 0; i < 8; i++) begin
      sel = i[2:0];
      #1;
      chk("dsel_val",    16'(dsel), 16'(dsel_exp[i]));
      chk("dsel_onehot", 16'($countones(dsel)), 16'h0001);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/slug_exec_units.md
Name: slug_exec_units

Overview:
- Bundles the three non-storage functional units of the 4-bit slug CPU into one block.
- 16-bit program counter (load/increment), 74181-style 4-bit ALU, and a 3-to-8 select decoder.
- The ALU and the decoder are purely combinational. Only the program counter is clocked.
- Sits between the microcode ROM control lines and the register/port arrays.

Parameters:
- PC_WIDTH, 16, program counter width. Only 16 needs to be supported.
- PC_RESET, 16'h0000, value the program counter takes on reset.

Ports:
- clk  input  1  system clock; the program counter updates on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- pc_ld  input  1  load program counter from pc_d.
- pc_inc  input  1  increment program counter.
- pc_d  input  16  load value (address bus).
- pc_q  output  16  current program counter value (program ROM address).
- alu_s  input  4  ALU function select S3..S0.
- alu_m  input  1  mode: 1 = logic, 0 = arithmetic.
- alu_cn  input  1  carry-in, active-low (0 = carry present).
- alu_a  input  4  operand A (accumulator).
- alu_b  input  4  operand B.
- alu_f  output  4  ALU result.
- alu_cn4  output  1  carry-out, active-low (0 = carry/no-borrow).
- alu_zero  output  1  1 when alu_f == 4'h0.
- sel  input  3  decoder select.
- dsel  output  8  one-hot decode of sel, active-high.

Behaviour:

Program counter:
- Updates on posedge clk.
- Priority: rst==0 > pc_ld > pc_inc > hold.
  - rst==0 -> pc_q = PC_RESET.
  - pc_ld=1 -> pc_q = pc_d; pc_inc is ignored when pc_ld=1.
  - pc_inc=1 -> pc_q = pc_q + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - Otherwise hold.
- Reset is synchronous: asserting rst mid-count takes effect on the next edge only.
- pc_q is a registered output, valid one clock after load or increment.
- Reset value of pc_q is 16'h0000. There are no other registered outputs.

ALU:
- Combinational, zero latency, active-high data, 74181 function table.
- Logic mode (alu_m=1): alu_cn is ignored and alu_cn4 = 1. Function by S:
  - 0:~A
  - 1:~(A|B)
  - 2:~A&B
  - 3:0
  - 4:~(A&B)
  - 5:~B
  - 6:A^B
  - 7:A&~B
  - 8:~A|B
  - 9:~(A^B)
  - A:B
  - B:A&B
  - C:4'hF
  - D:A|~B
  - E:A|B
  - F:A
- Arithmetic mode (alu_m=0): result = X + Y + c, where c = ~alu_cn. Functions shown for c=0; c=1 adds 1:
  - 0:A
  - 1:A|B
  - 2:A|~B
  - 3:minus 1
  - 4:A+(A&~B)
  - 5:(A|B)+(A&~B)
  - 6:A-B-1
  - 7:(A&~B)-1
  - 8:A+(A&B)
  - 9:A+B
  - A:(A|~B)+(A&B)
  - B:(A&B)-1
  - C:A+A
  - D:(A|B)+A
  - E:(A|~B)+A
  - F:A-1
- "minus 1" means adding 4'hF.
- Computation is 5-bit: alu_f = sum[3:0]; alu_cn4 = ~sum[4].
- alu_zero = (alu_f == 0) in both modes.
- No X/Z propagation requirements beyond plain combinational logic.

Decoder:
- dsel = 8'b1 << sel; exactly one bit is high, always. No enable input.

Test Plan:
- Hold rst=0 for one edge, then release with pc_inc=1 for 3 edges -> pc_q 0000, 0001, 0002, 0003. Then load pc_d=FFFF, then inc -> FFFF, then 0000 (wrap).
- pc_ld=1, pc_inc=1, pc_d=1234 -> pc_q=1234. pc_ld=0, pc_inc=0 -> pc_q holds 1234. rst=0 while pc_inc=1 -> 0000 at the next edge, not before.
- Addition, M=0, S=9, cn=1:
  - A=5, B=3 -> F=8, cn4=1, zero=0.
  - A=9, B=9 -> F=2, cn4=0.
  - A=8, B=8 -> F=0, cn4=0, zero=1.
- Subtraction, M=0, S=6:
  - cn=0, A=5, B=3 -> F=2, cn4=0.
  - cn=0, A=3, B=5 -> F=E, cn4=1.
  - cn=1, A=5, B=3 -> F=1.
- Logic, M=1, A=A, B=6, cn toggled (cn4 must stay 1):
  - S=6 -> C.
  - S=B -> 2.
  - S=E -> E.
  - S=0 -> 5.
  - S=3 -> 0 with zero=1.
  - S=C -> F.
- Decoder: sweep sel 0..7 -> dsel 01, 02, 04, 08, 10, 20, 40, 80. Check one-hot for every value.
